montgomery_pipelined: RTL and testbench

MONTGOMERY_PIPELINED -- requirements
Module: montgomery_pipelined

---
 rtl/montgomery_pipelined.sv | 131 +++++++++++++
 tb/tb_montgomery_pipelined.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/montgomery_pipelined.sv
// montgomery_pipelined: streaming Montgomery reduction, result = x * 2^-k mod m.
// Define MONTGOMERY_BUSY_EN to add the busy_o output.
module montgomery_pipelined (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [63:0] x_i,
  input  logic [63:0] m_i,
  input  logic [63:0] m_bl_i,
  input  logic [63:0] minv_i,
  output logic [63:0] result_o,
  output logic        valid_o
`ifdef MONTGOMERY_BUSY_EN
  ,
  output logic        busy_o
`endif
);

  typedef struct packed {
    logic        v;
    logic [63:0] x;
  } in_t;

  typedef struct packed {
    logic        v;
    logic [63:0] x;
    logic [31:0] q;
  } s1_t;

  typedef struct packed {
    logic        v;
    logic [65:0] t;
  } s2_t;

  typedef struct packed {
    logic        v;
    logic [65:0] u;
  } s3_t;

  in_t s0_q;
  s1_t s1_q;
  s2_t s2_q;
  s3_t s3_q;

  logic [5:0]  k;
  logic [31:0] mask;
  logic [31:0] q_d;
  logic [63:0] qm;
  logic [65:0] t_d;
  logic [65:0] u_d;
  logic [65:0] m_ext;
  logic [65:0] diff;
  logic [63:0] res_d;

  // k >= 32 saturates the mask; such k is out of range anyway
  assign k    = m_bl_i[5:0];
  assign mask = k[5] ? 32'hFFFF_FFFF
                     : (32'd1 << k[4:0]) - 32'd1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s0_q <= '0;
    end else begin
      s0_q.v <= start_i;
      s0_q.x <= x_i;
    end
  end

  assign q_d = ((s0_q.x[31:0] & mask) *
                (minv_i[31:0] & mask)) & mask;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= '0;
    end else begin
      s1_q.v <= s0_q.v;
      s1_q.x <= s0_q.x;
      s1_q.q <= q_d;
    end
  end

  assign qm  = {32'b0, s1_q.q} * {32'b0, m_i[31:0]};
  assign t_d = {2'b00, s1_q.x} + {2'b00, qm};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_q <= '0;
    end else begin
      s2_q.v <= s1_q.v;
      s2_q.t <= t_d;
    end
  end

  // low k bits of t are zero, so the shift is an exact division
  assign u_d = s2_q.t >> k;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s3_q <= '0;
    end else begin
      s3_q.v <= s2_q.v;
      s3_q.u <= u_d;
    end
  end

  assign m_ext = {2'b00, m_i};
  assign diff  = s3_q.u - m_ext;
  assign res_d = (s3_q.u >= m_ext) ? diff[63:0]
                                   : s3_q.u[63:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o  <= 1'b0;
      result_o <= '0;
    end else begin
      valid_o <= s3_q.v;
      if (s3_q.v) begin
        result_o <= res_d;
      end
    end
  end

`ifdef MONTGOMERY_BUSY_EN
  assign busy_o = s0_q.v | s1_q.v | s2_q.v
                | s3_q.v | valid_o;
`endif

  logic unused;
  assign unused = ^{m_bl_i[63:6], minv_i[63:32], diff[65:64]};

endmodule

// File: tb/tb_montgomery_pipelined.sv
// tb_montgomery_pipelined: scoreboard bench for montgomery_pipelined.
// Build with MONTGOMERY_BUSY_EN defined to also check busy_o.
module tb_montgomery_pipelined;

  logic        clk_i   = 1'b0;
  logic        rst_i   = 1'b1;
  logic        start_i = 1'b0;
  logic [63:0] x_i     = '0;
  logic [63:0] m_i     = '0;
  logic [63:0] m_bl_i  = '0;
  logic [63:0] minv_i  = '0;
  logic [63:0] result_o;
  logic        valid_o;
`ifdef MONTGOMERY_BUSY_EN
  logic        busy_o;
`endif

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [63:0] exp_q[$];
  int          iss_q[$];
  logic [63:0] last_res = '0;

  montgomery_pipelined dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .x_i      (x_i),
    .m_i      (m_i),
    .m_bl_i   (m_bl_i),
    .minv_i   (minv_i),
    .result_o (result_o),
    .valid_o  (valid_o)
`ifdef MONTGOMERY_BUSY_EN
    ,
    .busy_o   (busy_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] expv);
    n_chk++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // reference: reduce mod m, then halve mod m k times
  function automatic logic [63:0] model(input logic [63:0] x,
                                        input logic [63:0] m,
                                        input int k);
    logic [63:0] r;
    r = x % m;
    for (int i = 0; i < k; i++) begin
      if (r[0]) r = (r + m) >> 1;
      else      r = r >> 1;
    end
    return r;
  endfunction

  always @(posedge clk_i) begin : mon
    logic [63:0] e;
    int          li;
    #1;
    if (rst_i) begin
      chk("rst_valid", {63'b0, valid_o}, 64'd0);
      chk("rst_result", result_o, 64'd0);
`ifdef MONTGOMERY_BUSY_EN
      chk("rst_busy", {63'b0, busy_o}, 64'd0);
`endif
      last_res = '0;
    end else if (valid_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", {63'b0, valid_o}, 64'd0);
      end else begin
        e  = exp_q.pop_front();
        li = iss_q.pop_front();
        chk("result", result_o, e);
        chk("latency", 64'(cyc - li), 64'd4);
        chk("in_range", {63'b0, result_o < m_i}, 64'd1);
      end
      last_res = result_o;
    end else begin
      chk("hold", result_o, last_res);
    end
  end

  task automatic cfg(input logic [63:0] m,
                     input logic [63:0] k,
                     input logic [63:0] minv);
    @(negedge clk_i);
    m_i = m; m_bl_i = k; minv_i = minv;
  endtask

  task automatic send(input logic [63:0] x,
                      input logic [63:0] e,
                      input bit push);
    @(negedge clk_i);
    start_i = 1'b1;
    x_i     = x;
    if (push) begin
      exp_q.push_back(e);
      iss_q.push_back(cyc + 1);
    end
  endtask

  task automatic nop();
    @(negedge clk_i);
    start_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    nop();
    while (exp_q.size() != 0 && n < 32) begin
      @(negedge clk_i);
      n++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
    repeat (2) @(negedge clk_i);
  endtask

  localparam logic [63:0] KM   = 64'hD01;
  localparam logic [63:0] KINV = 64'hFFFF_FFFF_FFFF_FCFF;
  localparam logic [63:0] DM   = 64'h7FE001;
  localparam logic [63:0] DINV = 64'hFFFF_FFFF_FFFF_DFFF;

  initial begin
    int first;
    int last;
    logic [63:0] r;

    cfg(KM, 64'd12, KINV);
    // input offered during reset must vanish
    start_i = 1'b1;
    x_i     = 64'h2FF;
    repeat (3) @(negedge clk_i);
    rst_i   = 1'b0;
    start_i = 1'b0;
    repeat (6) begin
      @(negedge clk_i);
      chk("post_rst_idle", {63'b0, valid_o}, 64'd0);
    end

    send(64'h2FF, 64'd1, 1'b1);
    drain();

    for (int a = 0; a < 10; a++)
      send(64'((a * 4096) % 3329), 64'(a), 1'b1);
    drain();

    send(64'hD00FFF, model(64'hD00FFF, KM, 12), 1'b1);
    send(64'h5FE, 64'd2, 1'b1);
    for (int i = 0; i < 8; i++) begin
      r = 64'($urandom_range(0, 32'hD00FFF));
      send(r, model(r, KM, 12), 1'b1);
    end
    drain();

    send(64'h11, model(64'h11, KM, 12), 1'b1);
    first = iss_q[$];
    nop();
    send(64'h222, model(64'h222, KM, 12), 1'b1);
    send(64'h3333, model(64'h3333, KM, 12), 1'b1);
    last = iss_q[$];
    nop();
`ifdef MONTGOMERY_BUSY_EN
    while (cyc <= last + 5) begin
      @(negedge clk_i);
      chk("busy", {63'b0, busy_o},
          {63'b0, (cyc >= first && cyc <= last + 4)});
    end
`endif
    drain();

    // reset lands on the edge carrying the third input
    send(64'h2FF, 64'd0, 1'b0);
    send(64'h5FE, 64'd0, 1'b0);
    @(negedge clk_i);
    rst_i   = 1'b1;
    start_i = 1'b1;
    x_i     = 64'h100;
    @(negedge clk_i);
    rst_i   = 1'b0;
    start_i = 1'b0;
    repeat (8) begin
      @(negedge clk_i);
      chk("rst_flush", {63'b0, valid_o}, 64'd0);
    end
    send(64'h2FF, 64'd1, 1'b1);
    drain();

    cfg(DM, 64'd23, DINV);
    send(64'h1FFF, 64'd1, 1'b1);
    send(64'h0, 64'd0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      r = {32'($urandom), 32'($urandom)} % (DM << 23);
      send(r, model(r, DM, 23), 1'b1);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
